// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader
// Description : Streams a program image from a valid/ready source into a
//               5-bit-addressed memory, then releases the CPU core.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_loader #(
   parameter int WR_HOLD = 2,
   parameter int DEPTH   = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic       ld_valid,
   input  logic [7:0] ld_data,
   output logic       ld_ready,
   output logic [4:0] mem_addr,
   output logic [7:0] mem_data,
   output logic       mem_write,
   output logic       cpu_run,
   output logic       busy,
   output logic       done,
   output logic [5:0] load_cnt
);

   localparam logic [3:0] c_HOLD_LAST = 4'(WR_HOLD - 1);
   localparam logic [5:0] c_CNT_LAST  = 6'(DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_WRITE = 3'd2,
      S_NEXT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t     r_state, w_state_nxt;
   logic [3:0] r_hold,  w_hold_nxt;
   logic [4:0] r_addr,  w_addr_nxt;
   logic [7:0] r_data,  w_data_nxt;
   logic [5:0] r_cnt,   w_cnt_nxt;
   logic       r_write, w_write_nxt;
   logic       r_done,  w_done_nxt;
   logic       r_run,   w_run_nxt;
   logic       r_busy,  w_busy_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_hold  <= 4'd0;
         r_addr  <= 5'd0;
         r_data  <= 8'h00;
         r_cnt   <= 6'd0;
         r_write <= 1'b0;
         r_done  <= 1'b0;
         r_run   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_hold  <= w_hold_nxt;
         r_addr  <= w_addr_nxt;
         r_data  <= w_data_nxt;
         r_cnt   <= w_cnt_nxt;
         r_write <= w_write_nxt;
         r_done  <= w_done_nxt;
         r_run   <= w_run_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   // Every output is computed one cycle ahead so it can come straight off a flop.
   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_addr_nxt  = r_addr;
      w_data_nxt  = r_data;
      w_cnt_nxt   = r_cnt;
      w_write_nxt = 1'b0;
      w_done_nxt  = r_done;
      w_run_nxt   = r_run;

      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt = S_WAIT;
               w_addr_nxt  = 5'd0;
               w_cnt_nxt   = 6'd0;
               w_done_nxt  = 1'b0;
               w_run_nxt   = 1'b0;
            end
         end
         S_WAIT: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b0;
               w_run_nxt   = 1'b0;
            end else if (ld_valid) begin
               w_data_nxt  = ld_data;
               w_write_nxt = 1'b1;
               w_hold_nxt  = 4'd0;
               w_state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b0;
               w_run_nxt   = 1'b0;
            end else if (r_hold == c_HOLD_LAST) begin
               w_state_nxt = S_NEXT;
            end else begin
               w_write_nxt = 1'b1;
               w_hold_nxt  = r_hold + 4'd1;
            end
         end
         S_NEXT: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b0;
               w_run_nxt   = 1'b0;
            end else begin
               // The address stays on the last location instead of wrapping.
               w_cnt_nxt = r_cnt + 6'd1;
               if (r_cnt == c_CNT_LAST) begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
                  w_run_nxt   = 1'b1;
               end else begin
                  w_addr_nxt  = r_addr + 5'd1;
                  w_state_nxt = S_WAIT;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt == S_WAIT) || (w_state_nxt == S_WRITE) ||
                   (w_state_nxt == S_NEXT);
   end

   assign ld_ready  = (r_state == S_WAIT);
   assign mem_addr  = r_addr;
   assign mem_data  = r_data;
   assign mem_write = r_write;
   assign cpu_run   = r_run;
   assign busy      = r_busy;
   assign done      = r_done;
   assign load_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_loader
// Description : Directed self-checking bench for mem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       abort;
   logic       ld_valid;
   logic [7:0] ld_data;
   logic       ld_ready;
   logic [4:0] mem_addr;
   logic [7:0] mem_data;
   logic       mem_write;
   logic       cpu_run;
   logic       busy;
   logic       done;
   logic [5:0] load_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // write-pulse monitor state
   int         pulses;
   int         width_err;
   int         stab_err;
   int         cur_len;
   logic       prev_w;
   logic [4:0] cur_a;
   logic [7:0] cur_d;
   logic [7:0] img [32];
   int         wcnt [32];

   mem_loader #(.WR_HOLD(2), .DEPTH(32)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .ld_valid  (ld_valid),
      .ld_data   (ld_data),
      .ld_ready  (ld_ready),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_write (mem_write),
      .cpu_run   (cpu_run),
      .busy      (busy),
      .done      (done),
      .load_cnt  (load_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_write) begin
         if (!prev_w) begin
            pulses++;
            cur_len = 1;
            cur_a   = mem_addr;
            cur_d   = mem_data;
         end else begin
            cur_len++;
            if (mem_addr !== cur_a || mem_data !== cur_d) stab_err++;
         end
      end else if (prev_w) begin
         if (cur_len != 2) width_err++;
         img[cur_a] = cur_d;
         wcnt[cur_a]++;
      end
      prev_w = mem_write;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_mon();
      pulses    = 0;
      width_err = 0;
      stab_err  = 0;
      cur_len   = 0;
      prev_w    = 1'b0;
      for (int k = 0; k < 32; k++) begin
         img[k]  = 8'hFF;
         wcnt[k] = 0;
      end
   endtask

   function automatic int img_bad();
      int b = 0;
      for (int k = 0; k < 32; k++) begin
         logic [7:0] kv = 8'(k);
         if (img[k] !== kv || wcnt[k] != 1) b++;
      end
      return b;
   endfunction

   task automatic do_start();
      clr_mon();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_busy",    32'(busy),     32'd1);
      chk("start_run",     32'(cpu_run),  32'd0);
      chk("start_done",    32'(done),     32'd0);
      chk("start_cnt",     32'(load_cnt), 32'd0);
      chk("start_addr",    32'(mem_addr), 32'd0);
      chk("start_ready",   32'(ld_ready), 32'd1);
   endtask

   // Feeds bytes 0..nbytes-1; optional gaps and a stray start while busy.
   task automatic feed(input int nbytes, input bit gaps, input int start_at,
                       output int last_acc);
      int idx      = 0;
      int cyc      = 0;
      bit acc;
      bit injected = 1'b0;
      last_acc = -1;
      while (idx < nbytes && cyc < 3000) begin
         ld_valid = gaps ? ((cyc / 3) % 2 == 0) : 1'b1;
         ld_data  = ld_valid ? idx[7:0] : 8'hA5;
         start    = (idx == start_at) && !injected && ld_ready;
         acc      = ld_valid && ld_ready;
         tick();
         if (start) begin
            start    = 1'b0;
            injected = 1'b1;
            chk("busy_start_cnt",  32'(load_cnt), 32'(start_at));
            chk("busy_start_busy", 32'(busy),     32'd1);
         end
         if (acc) begin
            last_acc = cyc;
            idx++;
         end
         cyc++;
      end
      ld_valid = 1'b0;
      chk("feed_bytes", 32'(idx), 32'(nbytes));
   endtask

   task automatic finish_load();
      int n = 0;
      while (!done && n < 20) begin
         tick();
         n++;
      end
      chk("done_latency", 32'(n),         32'd3);
      chk("pulses",       32'(pulses),    32'd32);
      chk("pulse_width",  32'(width_err), 32'd0);
      chk("pulse_stable", 32'(stab_err),  32'd0);
      chk("image",        32'(img_bad()), 32'd0);
      chk("done",         32'(done),      32'd1);
      chk("cpu_run",      32'(cpu_run),   32'd1);
      chk("busy_done",    32'(busy),      32'd0);
      chk("load_cnt",     32'(load_cnt),  32'd32);
      chk("addr_hold",    32'(mem_addr),  32'd31);
      chk("ready_done",   32'(ld_ready),  32'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, 32'(ld_ready),  32'd0);
      chk({tag, "_addr"},  32'(mem_addr),  32'd0);
      chk({tag, "_data"},  32'(mem_data),  32'd0);
      chk({tag, "_write"}, 32'(mem_write), 32'd0);
      chk({tag, "_run"},   32'(cpu_run),   32'd0);
      chk({tag, "_busy"},  32'(busy),      32'd0);
      chk({tag, "_done"},  32'(done),      32'd0);
      chk({tag, "_cnt"},   32'(load_cnt),  32'd0);
   endtask

   initial begin
      int last;
      reset    = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      ld_valid = 1'b0;
      ld_data  = 8'h00;
      clr_mon();
      #12;
      chk_reset_vals("rst");
      tick();
      reset = 1'b1;

      // idle: abort and source activity do nothing without start
      abort    = 1'b1;
      ld_valid = 1'b1;
      tick();
      tick();
      abort    = 1'b0;
      ld_valid = 1'b0;
      chk("idle_busy",  32'(busy),     32'd0);
      chk("idle_ready", 32'(ld_ready), 32'd0);

      // gap-free load with timing of the last accept
      do_start();
      feed(32, 1'b0, -1, last);
      chk("last_accept_cycle", 32'(last), 32'd124);
      finish_load();

      // abort in DONE is ignored
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("done_abort_done", 32'(done),    32'd1);
      chk("done_abort_run",  32'(cpu_run), 32'd1);

      // restart from DONE, source with gaps
      do_start();
      feed(32, 1'b1, -1, last);
      finish_load();

      // stray start pulse at byte 10
      do_start();
      feed(32, 1'b0, 10, last);
      finish_load();

      // abort (with simultaneous start) during WRITE of byte 5
      do_start();
      feed(6, 1'b0, -1, last);
      chk("wr5_write", 32'(mem_write), 32'd1);
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      chk("abort_write", 32'(mem_write), 32'd0);
      chk("abort_busy",  32'(busy),      32'd0);
      chk("abort_run",   32'(cpu_run),   32'd0);
      chk("abort_done",  32'(done),      32'd0);
      chk("abort_cnt",   32'(load_cnt),  32'd5);
      chk("abort_addr",  32'(mem_addr),  32'd5);
      chk("abort_ready", 32'(ld_ready),  32'd0);
      tick();
      do_start();
      feed(32, 1'b0, -1, last);
      finish_load();

      // asynchronous reset mid-WRITE of byte 20
      do_start();
      feed(21, 1'b0, -1, last);
      chk("wr20_write", 32'(mem_write), 32'd1);
      reset = 1'b0;
      #2;
      chk_reset_vals("async");
      reset = 1'b1;
      tick();
      clr_mon();
      ld_valid = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      ld_valid = 1'b0;
      chk("post_rst_pulses", 32'(pulses), 32'd0);
      chk("post_rst_busy",   32'(busy),   32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL provide parameter WR_HOLD, default 2, meaning clk cycles mem_write is held high per byte (range 1..15); the hold lets the slower memory clock sample the strobe.
REQ-002 SHALL provide parameter DEPTH, default 32, meaning bytes per program image; it equals the 5-bit memory address space.
REQ-003 SHALL have port clk, input, 1, the single clock for all state.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that requests an image load.
REQ-006 SHALL have port abort, input, 1, which cancels an in-progress load.
REQ-007 SHALL have port ld_valid, input, 1, meaning the source byte on ld_data is valid.
REQ-008 SHALL have port ld_data, input, 8, the program byte from the source.
REQ-009 SHALL have port ld_ready, output, 1, meaning the loader accepts a byte this cycle.
REQ-010 SHALL have port mem_addr, output, 5, the memory write address.
REQ-011 SHALL have port mem_data, output, 8, the memory write data.
REQ-012 SHALL have port mem_write, output, 1, the memory write strobe.
REQ-013 SHALL have port cpu_run, output, 1, the CPU core release; 0 holds the core in reset.
REQ-014 SHALL have port busy, output, 1, high while a load is in progress.
REQ-015 SHALL have port done, output, 1, high after a complete image is written.
REQ-016 SHALL have port load_cnt, output, 6, the number of bytes written in the current load (0..32).

Function
REQ-017 SHALL implement the states IDLE, WAIT, WRITE, NEXT and DONE.
REQ-018 IDLE SHALL go to WAIT when start=1, and SHALL clear mem_addr, load_cnt, done and cpu_run on that transition.
REQ-019 In WAIT, ld_ready SHALL be 1, and ld_ready SHALL be 0 in every other state; ld_ready is a decode of the state only, with no dependence on ld_valid.
REQ-020 A byte SHALL be accepted at the clk edge where ld_valid=1 and ld_ready=1: ld_data is registered into mem_data and the FSM goes to WRITE.
REQ-021 WRITE SHALL drive mem_write=1 for exactly WR_HOLD consecutive cycles, with mem_addr and mem_data held stable throughout, then go to NEXT.
REQ-022 NEXT SHALL drive mem_write=0 for exactly one cycle and increment load_cnt.
REQ-023 From NEXT, if load_cnt before the increment was DEPTH-1, the FSM SHALL go to DONE; otherwise it SHALL increment mem_addr and go to WAIT.
REQ-024 Timing: a byte accepted at edge N SHALL give mem_write high in cycles N+1..N+WR_HOLD and ld_ready high again in cycle N+WR_HOLD+2; minimum throughput is therefore one byte per WR_HOLD+2 cycles.
REQ-025 mem_addr SHALL NOT wrap: after address 31 the FSM goes to DONE, and mem_addr holds 31.
REQ-026 DONE SHALL drive done=1, cpu_run=1 and busy=0.
REQ-027 A start pulse in DONE SHALL begin a new load: cpu_run drops to 0 on the next edge, and the loader behaves as in REQ-018.
REQ-028 busy SHALL be 1 in WAIT, WRITE and NEXT, and 0 in IDLE and DONE.
REQ-029 A start pulse while busy=1 SHALL be ignored.
REQ-030 abort=1 in WAIT, WRITE or NEXT SHALL force IDLE on the next edge with mem_write=0, done=0 and cpu_run=0; load_cnt and mem_addr retain their values.
REQ-031 abort in IDLE or DONE SHALL have no effect.
REQ-032 When abort and start are asserted in the same cycle, abort SHALL take priority if busy=1, and start SHALL be processed if busy=0.
REQ-033 A WRITE cut short by abort SHALL NOT count; load_cnt reflects fully written bytes only.
REQ-034 ld_valid asserted outside WAIT SHALL be ignored; the source holds its byte until ld_ready.
REQ-035 All outputs SHALL be registered except ld_ready.

Reset
REQ-036 reset=0 SHALL immediately, without waiting for clk, force IDLE with ld_ready=0, mem_addr=0, mem_data=0x00, mem_write=0, cpu_run=0, busy=0, done=0 and load_cnt=0.
REQ-037 Reset asserted during WRITE SHALL drop mem_write asynchronously.
REQ-038 After reset is released, the loader SHALL wait for start.

Verification
REQ-039 Full load, WR_HOLD=2, ld_valid held high with data 0x00..0x1F -> 32 write pulses each 2 cycles wide; address k carries data k; last ld_ready at cycle 124; done=1, cpu_run=1, load_cnt=32.
REQ-040 Source gaps, ld_valid toggling every 3 cycles -> no byte lost or duplicated; mem_write occurs only after acceptance; final image is identical to the gap-free run.
REQ-041 start pulsed at byte 10 -> ignored; load_cnt continues 11, 12, ...; no restart.
REQ-042 abort during WRITE of byte 5 -> mem_write=0 on the next edge; IDLE with busy=0 and cpu_run=0; load_cnt=5; a following start reloads from address 0.
REQ-043 reset=0 mid-WRITE of byte 20 -> all outputs return to reset values before the next clk edge; no further mem_write until a new start.
REQ-044 start in DONE -> cpu_run=0 on the next edge, busy=1, load_cnt=0, mem_addr=0, and a full reload completes again.
